sad_search_ctrl: RTL

SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

---
 rtl/sad_pkg.sv | 18 +
 rtl/sad_min_track.sv | 50 +++++
 rtl/sad_search_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared types and defaults for the SAD candidate search controller.
// MIN_INIT is wide enough for any supported SAD width; users slice it down.
package sad_pkg;

    localparam int ROW_W_DEF = 6;
    localparam int COL_W_DEF = 6;
    localparam int SAD_W_DEF = 32;

    localparam logic [63:0] MIN_INIT = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/sad_min_track.sv
// Running-minimum tracker for SAD results with the {row, col} of the best candidate.
// Uses <= so that on equal SAD values the later candidate wins the tie.
module sad_min_track
    import sad_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int SAD_W = SAD_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     init_i,
    input  logic                     clear_i,
    input  logic                     update_i,
    input  logic [SAD_W-1:0]         sad_value_i,
    input  logic [ROW_W-1:0]         row_i,
    input  logic [COL_W-1:0]         col_i,
    output logic [SAD_W-1:0]         min_sad_o,
    output logic [ROW_W+COL_W-1:0]   best_row_col_o
);

    logic [SAD_W-1:0]       min_q, min_d;
    logic [ROW_W+COL_W-1:0] best_q, best_d;

    always_comb begin
        min_d  = min_q;
        best_d = best_q;
        if (init_i || clear_i) begin
            min_d  = MIN_INIT[SAD_W-1:0];
            best_d = '0;
        end else if (update_i && (sad_value_i <= min_q)) begin
            min_d  = sad_value_i;
            best_d = {row_i, col_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            min_q  <= MIN_INIT[SAD_W-1:0];
            best_q <= '0;
        end else begin
            min_q  <= min_d;
            best_q <= best_d;
        end
    end

    assign min_sad_o      = min_q;
    assign best_row_col_o = best_q;

endmodule

// File: rtl/sad_search_ctrl.sv
// Row-major full-search controller: issues one candidate at a time to the SAD
// datapath, waits for its result and keeps the best (lowest) SAD seen.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for start; outputs quiet, results held
//   ST_ISSUE  | one-cycle issue pulse for the current row/col
//   ST_WAIT   | row/col held until the datapath returns sad_valid
//   ST_FINISH | one-cycle done pulse, then back to idle
module sad_search_ctrl
    import sad_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int SAD_W = SAD_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [ROW_W-1:0]         max_row_i,
    input  logic [COL_W-1:0]         max_col_i,
    input  logic                     sad_valid_i,
    input  logic [SAD_W-1:0]         sad_value_i,
    output logic                     issue_o,
    output logic [ROW_W-1:0]         row_o,
    output logic [COL_W-1:0]         col_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [SAD_W-1:0]         min_sad_o,
    output logic [ROW_W+COL_W-1:0]   best_row_col_o
);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d, max_row_q, max_row_d;
    logic [COL_W-1:0] col_q, col_d, max_col_q, max_col_d;

    logic start_acc;
    logic abort_acc;
    logic result_acc;
    logic last_cand;

    assign start_acc  = (state_q == ST_IDLE) && start_i;
    assign abort_acc  = (state_q != ST_IDLE) && abort_i;
    assign result_acc = (state_q == ST_WAIT) && sad_valid_i && !abort_i;
    assign last_cand  = (row_q == max_row_q) && (col_q == max_col_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   if (sad_valid_i) state_d = last_cand ? ST_FINISH : ST_ISSUE;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // Abort overrides everything once a search is under way.
        if (abort_acc) state_d = ST_IDLE;
    end

    always_comb begin
        issue_o = 1'b0;
        done_o  = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                issue_o = !abort_i;
                busy_o  = 1'b1;
            end
            ST_WAIT:   busy_o = 1'b1;
            ST_FINISH: done_o = !abort_i;
            default: ;
        endcase
    end

    // Index stops at the last candidate instead of wrapping, so all-ones maxima are safe.
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        max_row_d = max_row_q;
        max_col_d = max_col_q;
        if (start_acc) begin
            max_row_d = max_row_i;
            max_col_d = max_col_i;
            row_d     = '0;
            col_d     = '0;
        end else if (abort_acc) begin
            row_d = '0;
            col_d = '0;
        end else if (result_acc && !last_cand) begin
            if (col_q == max_col_q) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q     <= '0;
            col_q     <= '0;
            max_row_q <= '0;
            max_col_q <= '0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            max_row_q <= max_row_d;
            max_col_q <= max_col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

    sad_min_track #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .SAD_W (SAD_W)
    ) u_min_track (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .init_i         (start_acc),
        .clear_i        (abort_acc),
        .update_i       (result_acc),
        .sad_value_i    (sad_value_i),
        .row_i          (row_q),
        .col_i          (col_q),
        .min_sad_o      (min_sad_o),
        .best_row_col_o (best_row_col_o)
    );

endmodule
